// File: rtl/fft_r22sdf_reorder_if.sv
// Sample stream carrying one complex FFT bin per beat with ready/valid flow control.
// The producer drives valid/re/im/last and the consumer drives ready.
`timescale 1ns/1ps
interface fft_r22sdf_reorder_if #(
   parameter int DATA_WIDTH = 25
);
   logic                         valid;
   logic                         ready;
   logic signed [DATA_WIDTH-1:0] re;
   logic signed [DATA_WIDTH-1:0] im;
   logic                         last;

   modport master (output valid, re, im, last, input ready);
   modport slave  (input valid, re, im, last, output ready);
endinterface

// File: rtl/fft_r22sdf_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order frames out.
// Each bank holds one frame; write and read sides own one bank each at any time.
`timescale 1ns/1ps
module fft_r22sdf_reorder #(
   parameter int DATA_WIDTH = 25,
   parameter int N_LOG2     = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fft_r22sdf_reorder_if.slave  s_in,
   fft_r22sdf_reorder_if.master m_out
);
   localparam int N  = 1 << N_LOG2;
   localparam int SW = 2 * DATA_WIDTH;

   typedef logic [N_LOG2-1:0] idx_t;
   localparam idx_t LAST_IDX = idx_t'(N - 1);

   function automatic idx_t bitrev(input idx_t v);
      idx_t r;
      for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
      return r;
   endfunction

   logic [SW-1:0] mem [2*N];

   idx_t        wcnt, rcnt;
   logic        wbank, rbank;
   logic [1:0]  full, full_nxt;
   logic        accept, issue, wr_last, rd_last;

   logic                         out_valid, out_last;
   logic signed [DATA_WIDTH-1:0] out_re, out_im;

   assign accept  = s_in.valid && !full[wbank];
   assign issue   = full[rbank] && (!out_valid || m_out.ready);
   assign wr_last = accept && (wcnt == LAST_IDX);
   assign rd_last = issue && (rcnt == LAST_IDX);

   // Set and clear always target different banks: set needs full[wbank]=0, clear needs full[rbank]=1.
   always_comb begin
      // NOTE: default assignment first so the conditional updates below never infer a latch.
      full_nxt = full;
      if (wr_last) full_nxt[wbank] = 1'b1;
      if (rd_last) full_nxt[rbank] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
      if (rst_i) begin
         wcnt  <= '0;
         rcnt  <= '0;
         wbank <= 1'b0;
         rbank <= 1'b0;
         full  <= '0;
      end else begin
         if (accept) begin
            wcnt <= wcnt + 1'b1;
            if (wr_last) wbank <= !wbank;
         end
         if (issue) begin
            rcnt <= rcnt + 1'b1;
            if (rd_last) rbank <= !rbank;
         end
         full <= full_nxt;
      end
   end

   // NOTE: the frame store is deliberately not reset; stale entries are never read before being rewritten.
   always_ff @(posedge clk_i) begin
      if (accept) mem[{wbank, bitrev(wcnt)}] <= {s_in.re, s_in.im};
   end

   // Output register doubles as the synchronous read port of the frame store.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else if (issue) begin
         {out_re, out_im} <= mem[{rbank, rcnt}];
         out_last         <= (rcnt == LAST_IDX);
         out_valid        <= 1'b1;
      end else if (m_out.ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   assign s_in.ready  = !full[wbank];
   assign m_out.valid = out_valid;
   assign m_out.last  = out_last;
   assign m_out.re    = out_re;
   assign m_out.im    = out_im;
endmodule
